input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Conditions the raw board buttons and switches before they reach the SoC top level's iButton0..3 and iSwitch0..1 inputs.
- Per channel: 2-flop synchronizer, then a stability-counter debouncer.
- Outputs per channel: a clean registered level, plus one-cycle rise and fall event pulses.
- Sits between the board pins and the SoC, in the same clock domain as the SoC core clock (50 MHz).

Parameters:
- WIDTH, 6, number of independent channels (4 buttons + 2 switches).
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a level change is accepted (10 ms at 50 MHz). Legal range 2..2^24.
- CNT_WIDTH, derived localparam = clog2(DEBOUNCE_CYCLES), width of each channel's stability counter.

Ports:
- Clock  input  1  core clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- iRaw  input  WIDTH  asynchronous raw pin levels, active-high.
- oLevel  output  WIDTH  debounced level per channel.
- oRise  output  WIDTH  one-cycle pulse when oLevel[i] goes 0->1.
- oFall  output  WIDTH  one-cycle pulse when oLevel[i] goes 1->0.
- oAnyEvent  output  1  registered OR of oRise|oFall, same cycle as the pulses.

Behaviour:
- Reset (synchronous, active-high):
  - sync flops, oLevel, oRise, oFall, oAnyEvent and all counters go to 0.
  - Reset asserted mid-count discards the pending change.
- Synchronizer: sync1 <= iRaw; sync2 <= sync1. Only sync2 (called s) is used downstream. No logic between the two flops.
- Per-channel state machine: STABLE / COUNTING.
  - STABLE: cnt = 0. If s != oLevel, move to COUNTING with cnt <= 1.
  - COUNTING, s == oLevel (bounce back): cnt <= 0, go to STABLE, no pulse.
  - COUNTING, s != oLevel and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - COUNTING, s != oLevel and cnt == DEBOUNCE_CYCLES-1: oLevel <= s, cnt <= 0, go to STABLE, pulse the matching oRise/oFall for exactly one cycle.
- Latency: a clean input step first sampled at edge k appears on oLevel after edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges total. oRise/oFall/oAnyEvent are asserted in the same cycle as the new oLevel.
- Glitch rejection:
  - Any pulse on s shorter than DEBOUNCE_CYCLES cycles produces no output change.
  - A glitch of exactly DEBOUNCE_CYCLES-1 cycles must be rejected.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Channels are fully independent. Simultaneous events on several channels each pulse in their own bit; oAnyEvent is a single pulse.
- Pins held at 1 through reset: channel rises DEBOUNCE_CYCLES+2 edges after Reset deasserts and emits oRise. This is intended, so the SoC sees a power-on press.
- oRise and oFall are never both set for the same bit.
- All outputs are registered; no combinational path from iRaw.

Optional Feature:
- Macro: INPUT_DEBOUNCER_PRESS_COUNT_EN.
- When defined:
  - Adds output oPressCount, WIDTH*8 bits, one 8-bit counter per channel.
  - Counter increments on that channel's oRise and saturates at 255 (no wrap).
  - Cleared by Reset, or by new input iCountClear (1 bit) held high for one cycle. Clear has priority over a same-cycle increment.
- When undefined: neither port exists and no counter logic is generated. Base behaviour is identical in both builds.

Decomposition:
- Shared package input_debouncer_pkg:
  - state enum {STABLE, COUNTING}.
  - Default constant DEBOUNCE_10MS_AT_50MHZ = 500000.
  - Constant PRESS_COUNT_WIDTH = 8.
- One sub-module, debounce_channel: single-bit synchronizer, counter, FSM, level register and pulses. Instantiated WIDTH times in a generate loop.
- Top level contains only the generate loop, the oAnyEvent OR register and the optional press counters.

Test Plan (DEBOUNCE_CYCLES=4 for bench):
- Reset with iRaw=0; release, hold 20 cycles -> oLevel=0 and no pulses throughout.
- Step iRaw[0] 0->1 at edge k, hold -> oLevel[0]=1 after edge k+5; oRise[0] and oAnyEvent high only that cycle; oFall=0.
- iRaw[2] high for 3 cycles then low (glitch of DEBOUNCE_CYCLES-1) -> oLevel[2] stays 0 and no pulses. Repeat with 4 cycles -> oRise[2] fires, later oFall[2] after the return to 0.
- iRaw[1] and iRaw[5] step high on the same edge -> oRise=6'b100010 in a single cycle; oAnyEvent one pulse.
- iRaw[3] high, Reset asserted on the 3rd counting cycle -> no pulse; after release the channel re-counts from 0 and rises 6 edges later.
- PRESS_COUNT_EN: 300 clean presses on channel 4 -> oPressCount[39:32]=255. Assert iCountClear on the same cycle as an oRise -> 0.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input debouncer.
//   deb_state_e            : per-channel debounce FSM state
//   DEBOUNCE_10MS_AT_50MHZ : default stability window (10 ms at 50 MHz)
//   PRESS_COUNT_WIDTH      : width of each optional per-channel press counter
package input_debouncer_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_e;

    localparam int unsigned DEBOUNCE_10MS_AT_50MHZ = 500000;
    localparam int unsigned PRESS_COUNT_WIDTH      = 8;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: 2-flop synchronizer, stability counter, level register
// and one-cycle rise/fall pulses.
// Ports:
//   Clock   : core clock, rising edge
//   Reset   : synchronous, active-high
//   raw     : asynchronous raw pin level
//   level   : debounced level (registered)
//   rise    : one-cycle pulse on level 0->1 (registered)
//   fall    : one-cycle pulse on level 1->0 (registered)
//   event_c : combinational next-cycle rise|fall, lets the top register an
//             aggregate event flag that lines up with rise/fall
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_50MHZ
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic event_c
);

    localparam int unsigned         CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    deb_state_e           state_q;
    deb_state_e           state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 level_d;
    logic                 rise_d;
    logic                 fall_d;

    // State, synchronizer and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Next-state: a change is accepted only after DEBOUNCE_CYCLES consecutive
    // samples that differ from the current level; the first mismatching sample
    // is counted as 1 on entry to COUNTING.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        event_c = 1'b0;

        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync2_q != level) begin
                    state_d = COUNTING;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            COUNTING: begin
                if (sync2_q == level) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    level_d = sync2_q;
                    rise_d  = sync2_q;
                    fall_d  = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        event_c = rise_d | fall_d;
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces WIDTH raw board inputs (buttons/switches) into clean levels and
// one-cycle edge pulses for the SoC core.
// Optional feature (macro INPUT_DEBOUNCER_PRESS_COUNT_EN): per-channel 8-bit
// saturating press counters on oPressCount, cleared by iCountClear.
// Ports:
//   Clock       : core clock, rising edge
//   Reset       : synchronous, active-high
//   iRaw        : asynchronous raw pin levels
//   oLevel      : debounced levels
//   oRise/oFall : one-cycle edge pulses per channel
//   oAnyEvent   : OR of all pulses, aligned with them
//   iCountClear : (optional) clear all press counters
//   oPressCount : (optional) 8-bit press count per channel, channel i at [8i+7:8i]
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_AT_50MHZ
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] iRaw,
    output logic [WIDTH-1:0] oLevel,
    output logic [WIDTH-1:0] oRise,
    output logic [WIDTH-1:0] oFall,
    output logic             oAnyEvent
`ifdef INPUT_DEBOUNCER_PRESS_COUNT_EN
    ,
    input  logic                               iCountClear,
    output logic [WIDTH*PRESS_COUNT_WIDTH-1:0] oPressCount
`endif
);

    logic [WIDTH-1:0] event_c;

    // One independent debouncer per channel.
    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .Clock   (Clock),
            .Reset   (Reset),
            .raw     (iRaw[g]),
            .level   (oLevel[g]),
            .rise    (oRise[g]),
            .fall    (oFall[g]),
            .event_c (event_c[g])
        );
    end

    // Registered from the channels' next-cycle pulses so it lines up with oRise/oFall.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oAnyEvent <= 1'b0;
        end else begin
            oAnyEvent <= |event_c;
        end
    end

`ifdef INPUT_DEBOUNCER_PRESS_COUNT_EN
    localparam int unsigned PCW = PRESS_COUNT_WIDTH;

    // Saturating press counters; clear wins over a same-cycle increment.
    always_ff @(posedge Clock) begin
        if (Reset || iCountClear) begin
            oPressCount <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (oRise[i] && (oPressCount[i*PCW +: PCW] != {PCW{1'b1}})) begin
                    oPressCount[i*PCW +: PCW] <= oPressCount[i*PCW +: PCW] + PCW'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed testbench for input_debouncer with DEBOUNCE_CYCLES=4, WIDTH=6.
module tb_input_debouncer;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned DEB   = 4;

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] iRaw;
    logic [WIDTH-1:0] oLevel;
    logic [WIDTH-1:0] oRise;
    logic [WIDTH-1:0] oFall;
    logic             oAnyEvent;
`ifdef INPUT_DEBOUNCER_PRESS_COUNT_EN
    logic             iCountClear;
    logic [WIDTH*8-1:0] oPressCount;
`endif

    int n_checks;
    int n_pass;

    input_debouncer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iRaw        (iRaw),
        .oLevel      (oLevel),
        .oRise       (oRise),
        .oFall       (oFall),
        .oAnyEvent   (oAnyEvent)
`ifdef INPUT_DEBOUNCER_PRESS_COUNT_EN
        ,
        .iCountClear (iCountClear),
        .oPressCount (oPressCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] lvl,
                         input logic [WIDTH-1:0] rise, input logic [WIDTH-1:0] fall,
                         input logic any);
        n_checks++;
        assert ({oLevel, oRise, oFall, oAnyEvent} === {lvl, rise, fall, any}) n_pass++;
        else $error("FAIL %s: observed lvl=%b rise=%b fall=%b any=%b expected lvl=%b rise=%b fall=%b any=%b",
                    tag, oLevel, oRise, oFall, oAnyEvent, lvl, rise, fall, any);
    endtask

`ifdef INPUT_DEBOUNCER_PRESS_COUNT_EN
    task automatic check_cnt(input string tag, input logic [7:0] exp);
        n_checks++;
        assert (oPressCount[39:32] === exp) n_pass++;
        else $error("FAIL %s: observed count=%0d expected count=%0d", tag, oPressCount[39:32], exp);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        Reset    = 1'b1;
        iRaw     = '0;
`ifdef INPUT_DEBOUNCER_PRESS_COUNT_EN
        iCountClear = 1'b0;
`endif

        // Reset state and quiet inputs.
        tick(3);
        check("reset_state", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_quiet", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        end

        // Clean step on channel 0: accepted after edge k+5.
        iRaw = 6'b000001;
        tick(5);
        check("ch0_before_accept", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        tick(1);
        check("ch0_rise", 6'b000001, 6'b000001, 6'b000000, 1'b1);
        tick(1);
        check("ch0_rise_one_cycle", 6'b000001, 6'b000000, 6'b000000, 1'b0);

        // Glitch of DEB-1 cycles on channel 2 is rejected.
        iRaw = 6'b000101;
        tick(3);
        iRaw = 6'b000001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("ch2_glitch3_rejected", 6'b000001, 6'b000000, 6'b000000, 1'b0);
        end

        // Pulse of exactly DEB cycles on channel 2 is accepted, then falls.
        iRaw = 6'b000101;
        tick(4);
        iRaw = 6'b000001;
        tick(1);
        check("ch2_pulse4_pending", 6'b000001, 6'b000000, 6'b000000, 1'b0);
        tick(1);
        check("ch2_rise", 6'b000101, 6'b000100, 6'b000000, 1'b1);
        tick(3);
        check("ch2_fall_pending", 6'b000101, 6'b000000, 6'b000000, 1'b0);
        tick(1);
        check("ch2_fall", 6'b000001, 6'b000000, 6'b000100, 1'b1);
        tick(1);
        check("ch2_fall_one_cycle", 6'b000001, 6'b000000, 6'b000000, 1'b0);

        // Simultaneous rise on channels 1 and 5.
        iRaw = 6'b100011;
        tick(5);
        check("ch15_pending", 6'b000001, 6'b000000, 6'b000000, 1'b0);
        tick(1);
        check("ch15_rise", 6'b100011, 6'b100010, 6'b000000, 1'b1);
        tick(1);
        check("ch15_one_pulse", 6'b100011, 6'b000000, 6'b000000, 1'b0);

        // Reset on channel 3's third counting cycle discards the change; held
        // pins then all rise together DEB+2 edges after release.
        iRaw = 6'b101011;
        tick(4);
        check("ch3_counting", 6'b100011, 6'b000000, 6'b000000, 1'b0);
        Reset = 1'b1;
        tick(1);
        check("mid_count_reset", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        Reset = 1'b0;
        tick(5);
        check("post_reset_pending", 6'b000000, 6'b000000, 6'b000000, 1'b0);
        tick(1);
        check("post_reset_rise", 6'b101011, 6'b101011, 6'b000000, 1'b1);
        tick(1);
        check("post_reset_settled", 6'b101011, 6'b000000, 6'b000000, 1'b0);

`ifdef INPUT_DEBOUNCER_PRESS_COUNT_EN
        // Press counter on channel 4: counts rises and saturates at 255.
        check_cnt("cnt_after_reset", 8'd0);
        for (int p = 0; p < 300; p++) begin
            iRaw[4] = 1'b1;
            tick(8);
            iRaw[4] = 1'b0;
            tick(8);
            if (p == 0) check_cnt("cnt_first_press", 8'd1);
        end
        check_cnt("cnt_saturated", 8'd255);

        // Clear coinciding with an oRise wins over the increment.
        iRaw[4] = 1'b1;
        tick(6);
        check("ch4_rise_for_clear", 6'b111011, 6'b010000, 6'b000000, 1'b1);
        iCountClear = 1'b1;
        tick(1);
        iCountClear = 1'b0;
        check_cnt("cnt_clear_priority", 8'd0);
        tick(1);
        check_cnt("cnt_stays_cleared", 8'd0);
        iRaw[4] = 1'b0;
        tick(8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
